// File: rtl/mp3_mem_arbiter_pkg.sv
// lc3b_types: shared types for the mp3 memory hierarchy.
//   lc3b_word        16-bit word / byte address
//   lc3b_l1_line     128-bit L1 cache line
//   arb_state_t      memory arbiter grant state
//   LINE_OFFSET_BITS byte-offset width inside one line
//   line_align()     clears the byte offset of an address
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_l1_line;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    localparam int unsigned LINE_OFFSET_BITS = 4;

    function automatic lc3b_word line_align(input lc3b_word addr);
        lc3b_word aligned;
        aligned = addr;
        aligned[LINE_OFFSET_BITS-1:0] = '0;
        return aligned;
    endfunction

endpackage

// File: rtl/mp3_mem_arbiter_arb_pick.sv
// arb_pick: combinational winner selection between the I-cache and the
// D-cache request lines.
//   i_req_i / i_req_d   pending requests
//   i_last_grant_d      1 if the previous grant went to D (round-robin build only)
//   o_grant_i/o_grant_d one-hot (or zero) grant
// Build option: MP3_ARB_ROUND_ROBIN_EN selects round-robin on collisions;
// otherwise D always beats I.
module arb_pick (
    input  logic i_req_i,
    input  logic i_req_d,
`ifdef MP3_ARB_ROUND_ROBIN_EN
    input  logic i_last_grant_d,
`endif
    output logic o_grant_i,
    output logic o_grant_d
);

    always_comb begin
        o_grant_i = 1'b0;
        o_grant_d = 1'b0;
`ifdef MP3_ARB_ROUND_ROBIN_EN
        if (i_req_i && i_req_d) begin
            // collision: the side not served last time wins
            o_grant_d = ~i_last_grant_d;
            o_grant_i = i_last_grant_d;
        end else begin
            o_grant_d = i_req_d;
            o_grant_i = i_req_i;
        end
`else
        o_grant_d = i_req_d;
        o_grant_i = i_req_i & ~i_req_d;
`endif
    end

endmodule

// File: rtl/mp3_mem_arbiter.sv
// mp3_mem_arbiter: merges L1 I-cache (read-only) and L1 D-cache (read/write)
// line traffic onto the single physical-memory port, one transaction at a time.
//   clk, rst                       clock, async active-high reset
//   icache_read/address            I-cache fill request
//   icache_rdata/resp              fill data / completion
//   dcache_read/write/address/wdata D-cache fill or writeback request
//   dcache_rdata/resp              fill data / completion
//   pmem_read/write/address/wdata  registered memory command
//   pmem_rdata/resp                memory return
// Build option: MP3_ARB_ROUND_ROBIN_EN (round-robin on simultaneous requests;
// default is fixed D-over-I priority).
module mp3_mem_arbiter
    import lc3b_types::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         icache_read,
    input  logic [15:0]  icache_address,
    output logic [127:0] icache_rdata,
    output logic         icache_resp,
    input  logic         dcache_read,
    input  logic         dcache_write,
    input  logic [15:0]  dcache_address,
    input  logic [127:0] dcache_wdata,
    output logic [127:0] dcache_rdata,
    output logic         dcache_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    logic        r_read;
    logic        r_write;
    lc3b_word    r_addr;
    lc3b_l1_line r_wdata;
    logic        w_grant_i;
    logic        w_grant_d;

`ifdef MP3_ARB_ROUND_ROBIN_EN
    logic        r_last_grant_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant_d <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_grant_d)      r_last_grant_d <= 1'b1;
            else if (w_grant_i) r_last_grant_d <= 1'b0;
        end
    end
`endif

    arb_pick u_pick (
        .i_req_i        (icache_read),
        .i_req_d        (dcache_read | dcache_write),
`ifdef MP3_ARB_ROUND_ROBIN_EN
        .i_last_grant_d (r_last_grant_d),
`endif
        .o_grant_i      (w_grant_i),
        .o_grant_d      (w_grant_d)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // next-state logic
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant_d)      w_next_state = SERVE_D;
                else if (w_grant_i) w_next_state = SERVE_I;
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Command/address latches: loaded on grant, command cleared with the
    // response so pmem_read/pmem_write are pure flop outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == IDLE) begin
            if (w_grant_d) begin
                r_read  <= dcache_read;
                r_write <= dcache_write;
                r_addr  <= line_align(dcache_address);
                r_wdata <= dcache_wdata;
            end else if (w_grant_i) begin
                r_read  <= 1'b1;
                r_write <= 1'b0;
                r_addr  <= line_align(icache_address);
                r_wdata <= '0;
            end
        end else if (pmem_resp) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
        end
    end

    // outputs
    always_comb begin
        pmem_read    = r_read;
        pmem_write   = r_write;
        pmem_address = r_addr;
        pmem_wdata   = r_wdata;
        icache_rdata = pmem_rdata;
        dcache_rdata = pmem_rdata;
        icache_resp  = (r_state == SERVE_I) & pmem_resp;
        dcache_resp  = (r_state == SERVE_D) & pmem_resp;
    end

endmodule

// File: tb/tb_mp3_mem_arbiter.sv
// Scoreboard bench for mp3_mem_arbiter: directed requests push expected
// memory transactions; a monitor compares them when pmem_resp fires.
module tb_mp3_mem_arbiter;

    logic         clk;
    logic         rst;
    logic         icache_read;
    logic [15:0]  icache_address;
    logic [127:0] icache_rdata;
    logic         icache_resp;
    logic         dcache_read;
    logic         dcache_write;
    logic [15:0]  dcache_address;
    logic [127:0] dcache_wdata;
    logic [127:0] dcache_rdata;
    logic         dcache_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    mp3_mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         is_d;
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } exp_t;

    exp_t         exp_q[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    logic [127:0] mem_data = '0;
    int           last_gap = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic push(input logic is_d, input logic rd, input logic wr,
                        input logic [15:0] addr, input logic [127:0] wdata,
                        input logic [127:0] rdata);
        exp_t e;
        e.is_d = is_d; e.rd = rd; e.wr = wr;
        e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    // memory model: responds on the third cycle of a held command
    initial begin
        int cnt;
        cnt = 0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                cnt = 0;
                pmem_resp = 1'b0;
            end else if ((pmem_read || pmem_write) && !pmem_resp) begin
                cnt++;
                if (cnt == 3) begin
                    pmem_resp = 1'b1;
                    pmem_rdata = mem_data;
                end
            end else begin
                cnt = 0;
                pmem_resp = 1'b0;
            end
        end
    end

    // monitor
    initial begin
        int cmd_len;
        int idle_cnt;
        exp_t e;
        cmd_len = 0;
        idle_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cmd_len = 0;
                idle_cnt = 0;
            end else begin
                if (pmem_read || pmem_write) begin
                    cmd_len++;
                    if (idle_cnt > 0) begin
                        last_gap = idle_cnt;
                        idle_cnt = 0;
                    end
                end else begin
                    idle_cnt++;
                end
                if (!pmem_resp && (icache_resp || dcache_resp)) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL stray_resp: got i=%0b d=%0b required 0", icache_resp, dcache_resp);
                end
                if (pmem_resp) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_txn: got addr %0h with no expected entry", pmem_address);
                    end else begin
                        e = exp_q.pop_front();
                        check("icache_resp", {127'b0, icache_resp}, {127'b0, ~e.is_d});
                        check("dcache_resp", {127'b0, dcache_resp}, {127'b0, e.is_d});
                        check("pmem_address", {112'b0, pmem_address}, {112'b0, e.addr});
                        check("pmem_read", {127'b0, pmem_read}, {127'b0, e.rd});
                        check("pmem_write", {127'b0, pmem_write}, {127'b0, e.wr});
                        if (e.wr) check("pmem_wdata", pmem_wdata, e.wdata);
                        if (e.is_d) check("dcache_rdata", dcache_rdata, e.rdata);
                        else        check("icache_rdata", icache_rdata, e.rdata);
                        check("cmd_cycles", 128'(cmd_len), 128'd3);
                    end
                    cmd_len = 0;
                end
            end
        end
    end

    task automatic drive_i(input logic [15:0] a, input int drop_at);
        bit got;
        got = 0;
        icache_address = a;
        icache_read = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (drop_at > 0 && k == drop_at) icache_read = 1'b0;
            if (icache_resp) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout_i: got no icache_resp required one for %0h", a);
        end
        @(posedge clk);
        #1 icache_read = 1'b0;
    endtask

    task automatic drive_d(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [127:0] wd);
        bit got;
        got = 0;
        dcache_address = a;
        dcache_wdata = wd;
        dcache_read = rd;
        dcache_write = wr;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (dcache_resp) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout_d: got no dcache_resp required one for %0h", a);
        end
        @(posedge clk);
        #1;
        dcache_read = 1'b0;
        dcache_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        icache_read = 1'b0;
        icache_address = '0;
        dcache_read = 1'b0;
        dcache_write = 1'b0;
        dcache_address = '0;
        dcache_wdata = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_pmem_read", {127'b0, pmem_read}, 128'd0);
        check("rst_pmem_write", {127'b0, pmem_write}, 128'd0);
        check("rst_pmem_address", {112'b0, pmem_address}, 128'd0);
        check("rst_pmem_wdata", pmem_wdata, 128'd0);
        check("rst_icache_resp", {127'b0, icache_resp}, 128'd0);
        check("rst_dcache_resp", {127'b0, dcache_resp}, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // lone I fill
        mem_data = 128'h1CACE;
        push(1'b0, 1'b1, 1'b0, 16'h1230, '0, 128'h1CACE);
        drive_i(16'h1234, 0);

        // lone D writeback
        @(negedge clk);
        mem_data = 128'h77;
        push(1'b1, 1'b0, 1'b1, 16'h5670, 128'hDCACE, 128'h77);
        drive_d(1'b0, 1'b1, 16'h5678, 128'hDCACE);

        // D fill
        @(negedge clk);
        mem_data = 128'hD00D;
        push(1'b1, 1'b1, 1'b0, 16'hABC0, '0, 128'hD00D);
        drive_d(1'b1, 1'b0, 16'hABCF, 128'h0);

        // simultaneous requests; last grant was D
        @(negedge clk);
        mem_data = 128'h5A5A;
`ifdef MP3_ARB_ROUND_ROBIN_EN
        push(1'b0, 1'b1, 1'b0, 16'h2220, '0, 128'h5A5A);
        push(1'b1, 1'b1, 1'b0, 16'h3330, '0, 128'h5A5A);
`else
        push(1'b1, 1'b1, 1'b0, 16'h3330, '0, 128'h5A5A);
        push(1'b0, 1'b1, 1'b0, 16'h2220, '0, 128'h5A5A);
`endif
        fork
            drive_d(1'b1, 1'b0, 16'h333F, 128'h0);
            drive_i(16'h2222, 0);
        join
        check("turnaround_gap", 128'(last_gap), 128'd1);

        // I request dropped mid-fill
        @(negedge clk);
        mem_data = 128'hF00D;
        push(1'b0, 1'b1, 1'b0, 16'h4440, '0, 128'hF00D);
        drive_i(16'h4448, 1);

        // reset during SERVE_D
        @(negedge clk);
        dcache_address = 16'h7777;
        dcache_read = 1'b1;
        @(posedge clk);
        #1 check("pre_rst_pmem_read", {127'b0, pmem_read}, 128'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_pmem_read", {127'b0, pmem_read}, 128'd0);
        check("async_rst_pmem_address", {112'b0, pmem_address}, 128'd0);
        check("async_rst_dcache_resp", {127'b0, dcache_resp}, 128'd0);
        dcache_read = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // normal fill after reset
        mem_data = 128'hBEEF;
        push(1'b0, 1'b1, 1'b0, 16'h9AB0, '0, 128'hBEEF);
        drive_i(16'h9AB7, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
